// File: rtl/neuron_mac_q88_pkg.sv
// Shared Q8.8 fixed-point constants and MAC controller state encoding,
// also used by the PWL tanh stages.
package neuron_mac_q88_pkg;

  localparam int Q_FRAC     = 8;
  localparam int Q_MAX      = 32767;
  localparam int Q_MIN      = -32768;
  localparam int ROUND_HALF = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } mac_state_t;

endpackage

// File: rtl/neuron_mac_q88_round_sat.sv
// Converts a Q(ACC_W-16).16 accumulator to Q8.8:
// round-half-up, arithmetic shift, then clamp to the 16-bit signed range.
module q88_round_sat
  import neuron_mac_q88_pkg::*;
#(
  parameter int unsigned ACC_W = 40
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [15:0]      y
);

  logic signed [ACC_W-1:0] rounded;
  logic signed [ACC_W-1:0] shifted;

  assign rounded = acc + ACC_W'(ROUND_HALF);
  assign shifted = rounded >>> Q_FRAC;

  always_comb begin
    if (shifted > ACC_W'(Q_MAX)) begin
      y = 16'sh7FFF;
    end else if (shifted < ACC_W'(Q_MIN)) begin
      y = 16'sh8000;
    end else begin
      y = shifted[15:0];
    end
  end

endmodule

// File: rtl/neuron_mac_q88.sv
// Q8.8 neuron multiply-accumulate: bias plus N_INPUTS streamed x*w products,
// producing a rounded, saturated Q8.8 pre-activation with a one-cycle valid pulse.
module neuron_mac_q88
  import neuron_mac_q88_pkg::*;
#(
  parameter int unsigned N_INPUTS = 8,
  parameter int unsigned ACC_W    = 40
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic signed [15:0] bias,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [15:0] x_in,
  input  logic signed [15:0] w_in,
  output logic               busy,
  output logic               valid_out,
  output logic signed [15:0] y_out
);

  localparam int unsigned CW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

  mac_state_t              state_q, state_d;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_sum;
  logic [CW-1:0]           count_q;
  logic signed [31:0]      prod;
  logic signed [15:0]      y_rs;
  logic                    accept;
  logic                    last;

  assign prod    = x_in * w_in;
  assign acc_sum = acc_q + {{(ACC_W-32){prod[31]}}, prod};
  assign accept  = in_valid && in_ready;
  assign last    = (count_q == CW'(N_INPUTS - 1));

  // Rounds the sum including the final product, so y_out is ready in the DONE cycle.
  q88_round_sat #(.ACC_W(ACC_W)) u_round_sat (
    .acc (acc_sum),
    .y   (y_rs)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_d = ST_ACC;
      end
      ST_ACC: begin
        in_ready = 1'b1;
        if (accept && last) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      count_q   <= '0;
      valid_out <= 1'b0;
      y_out     <= '0;
    end else begin
      valid_out <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            acc_q   <= {{(ACC_W-24){bias[15]}}, bias, 8'h00};
            count_q <= '0;
          end
        end
        ST_ACC: begin
          if (accept) begin
            acc_q   <= acc_sum;
            count_q <= count_q + 1'b1;
            if (last) begin
              y_out     <= y_rs;
              valid_out <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
